// File: rtl/pixel_pos_tracker_pkg.sv
// Shared sprite-pipeline definitions: FSM encodings, default raster size and the per-line event bundle.
package pixel_pos_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    BLANK  = 2'b10
  } state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  // One-cycle line/frame event pulses, registered together.
  typedef struct packed {
    logic line_done;
    logic frame_done;
    logic line_err;
  } evt_t;

endpackage

// File: rtl/pixel_pos_tracker_sync_edge_det.sv
// Rising-edge detector for a sync pin sampled on clk. The first cycle after reset never reports an
// edge, so a sync line held high across reset release is not mistaken for a new line/frame.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;
  logic armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= 1'b0;
      armed <= 1'b0;
    end else begin
      q     <= d;
      armed <= 1'b1;
    end
  end

  assign rise = armed & d & ~q;

endmodule

// File: rtl/pixel_pos_tracker.sv
// Active-video position tracker: h/v counters, line/frame pulses and short-line detection.
// Optional sprite window flag is built when SPRITE_WINDOW_EN is defined.
module pixel_pos_tracker
  import pixel_pos_tracker_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int HW       = 10,
  parameter int VW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pixel_clk,
  input  logic          h_sync,
  input  logic          v_sync,
  output logic [HW-1:0] h_pos_out,
  output logic [VW-1:0] v_pos_out,
  output logic          active_finder_position,
  output logic          line_done,
  output logic          frame_done,
  output logic          line_err
`ifdef SPRITE_WINDOW_EN
  ,
  input  logic [HW-1:0] win_x,
  input  logic [VW-1:0] win_y,
  input  logic [HW-1:0] win_w,
  input  logic [VW-1:0] win_h,
  output logic          in_window
`endif
);

  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);

  logic hs_rise, vs_rise;

  sync_edge_det u_hs_edge (.clk(clk), .rst(rst), .d(h_sync), .rise(hs_rise));
  sync_edge_det u_vs_edge (.clk(clk), .rst(rst), .d(v_sync), .rise(vs_rise));

  state_e          st, st_nxt;
  logic [HW-1:0]   h_nxt;
  logic [VW-1:0]   v_nxt;
  logic            act_nxt;
  logic            v_bump;
  evt_t            evt_q, evt_nxt;

  always_comb begin
    st_nxt  = st;
    h_nxt   = h_pos_out;
    v_nxt   = v_pos_out;
    act_nxt = active_finder_position;
    evt_nxt = '0;
    v_bump  = 1'b0;
    case (st)
      ACTIVE: begin
        if (pixel_clk && h_pos_out == H_LAST) begin
          // A coincident h_sync edge is a normal line end that immediately opens the next line.
          evt_nxt.line_done = 1'b1;
          v_bump            = 1'b1;
          h_nxt             = '0;
          st_nxt            = hs_rise ? ACTIVE : BLANK;
          act_nxt           = hs_rise;
        end else if (hs_rise) begin
          evt_nxt.line_err = 1'b1;
          v_bump           = 1'b1;
          h_nxt            = '0;
        end else if (pixel_clk) begin
          h_nxt = h_pos_out + HW'(1);
        end
      end
      default: begin
        if (hs_rise) begin
          st_nxt  = ACTIVE;
          h_nxt   = '0;
          act_nxt = 1'b1;
        end
      end
    endcase

    // Row advance wraps by explicit compare; frame_done only rides on a completed last row.
    if (v_bump) begin
      if (v_pos_out == V_LAST) begin
        v_nxt              = '0;
        evt_nxt.frame_done = evt_nxt.line_done;
      end else begin
        v_nxt = v_pos_out + VW'(1);
      end
    end

    if (vs_rise) begin
      v_nxt              = '0;
      evt_nxt.frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st                     <= IDLE;
      h_pos_out              <= '0;
      v_pos_out              <= '0;
      active_finder_position <= 1'b0;
      evt_q                  <= '0;
    end else begin
      st                     <= st_nxt;
      h_pos_out              <= h_nxt;
      v_pos_out              <= v_nxt;
      active_finder_position <= act_nxt;
      evt_q                  <= evt_nxt;
    end
  end

  assign line_done  = evt_q.line_done;
  assign frame_done = evt_q.frame_done;
  assign line_err   = evt_q.line_err;

`ifdef SPRITE_WINDOW_EN
  logic [HW:0] x_end;
  logic [VW:0] y_end;
  logic        win_nxt;

  // Window bounds carry one extra bit so x+w / y+h never wrap.
  assign x_end   = {1'b0, win_x} + {1'b0, win_w};
  assign y_end   = {1'b0, win_y} + {1'b0, win_h};
  assign win_nxt = act_nxt
                 && (h_nxt >= win_x) && ({1'b0, h_nxt} < x_end)
                 && (v_nxt >= win_y) && ({1'b0, v_nxt} < y_end);

  always_ff @(posedge clk) begin
    if (rst) in_window <= 1'b0;
    else     in_window <= win_nxt;
  end
`endif

endmodule

// File: tb/tb_pixel_pos_tracker.sv
// Bench for pixel_pos_tracker: directed line/frame scenarios plus randomized sync/pixel traffic,
// all checked every cycle against an integer position model.
module tb_pixel_pos_tracker;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int HW = 5;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pixel_clk;
  logic          h_sync;
  logic          v_sync;
  logic [HW-1:0] h_pos_out;
  logic [VW-1:0] v_pos_out;
  logic          active_finder_position;
  logic          line_done;
  logic          frame_done;
  logic          line_err;
`ifdef SPRITE_WINDOW_EN
  logic [HW-1:0] win_x, win_w;
  logic [VW-1:0] win_y, win_h;
  logic          in_window;
`endif

  pixel_pos_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .HW(HW), .VW(VW)) dut (
    .clk(clk),
    .rst(rst),
    .pixel_clk(pixel_clk),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .h_pos_out(h_pos_out),
    .v_pos_out(v_pos_out),
    .active_finder_position(active_finder_position),
    .line_done(line_done),
    .frame_done(frame_done),
    .line_err(line_err)
`ifdef SPRITE_WINDOW_EN
    ,
    .win_x(win_x),
    .win_y(win_y),
    .win_w(win_w),
    .win_h(win_h),
    .in_window(in_window)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0, fd_cnt = 0, le_cnt = 0;
  bit cmp_en = 1'b0;

  // Model state: plain integers describing where the beam is.
  int m_h = 0, m_v = 0;
  bit m_line = 0, m_ld = 0, m_fd = 0, m_le = 0, m_win = 0;
  bit hs_p = 0, vs_p = 0, armed = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_line = 0; m_h = 0; m_v = 0;
        m_ld = 0; m_fd = 0; m_le = 0; m_win = 0;
        armed = 0; hs_p = 0; vs_p = 0;
      end else begin
        bit hr, vr;
        int row;
        hr = armed && h_sync && !hs_p;
        vr = armed && v_sync && !vs_p;
        hs_p = h_sync; vs_p = v_sync; armed = 1;
        m_ld = 0; m_fd = 0; m_le = 0;
        row = m_v;
        if (m_line && pixel_clk && m_h == H - 1) begin
          m_ld = 1; m_h = 0; m_line = hr;
          m_v = (m_v + 1) % V;
          m_fd = (row == V - 1);
        end else if (m_line && hr) begin
          m_le = 1; m_h = 0;
          m_v = (m_v + 1) % V;
        end else if (m_line && pixel_clk) begin
          m_h = m_h + 1;
        end else if (!m_line && hr) begin
          m_line = 1; m_h = 0;
        end
        if (vr) begin
          m_v = 0; m_fd = 0;
        end
`ifdef SPRITE_WINDOW_EN
        m_win = m_line
             && m_h >= int'(win_x) && m_h < int'(win_x) + int'(win_w)
             && m_v >= int'(win_y) && m_v < int'(win_y) + int'(win_h);
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      ld_cnt += int'(line_done);
      fd_cnt += int'(frame_done);
      le_cnt += int'(line_err);
      if (cmp_en) begin
        chk("h_pos", int'(h_pos_out), m_h);
        chk("v_pos", int'(v_pos_out), m_v);
        chk("active", int'(active_finder_position), int'(m_line));
        chk("line_done", int'(line_done), int'(m_ld));
        chk("frame_done", int'(frame_done), int'(m_fd));
        chk("line_err", int'(line_err), int'(m_le));
`ifdef SPRITE_WINDOW_EN
        chk("in_window", int'(in_window), int'(m_win));
`endif
      end
    end
  end

  task automatic pulse_hs();
    h_sync = 1'b1;
    @(negedge clk);
    h_sync = 1'b0;
  endtask

  task automatic pixels(int n);
    for (int i = 0; i < n; i++) begin
      pixel_clk = 1'b1;
      @(negedge clk);
      pixel_clk = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic full_lines(int n);
    for (int i = 0; i < n; i++) begin
      pulse_hs();
      pixels(H);
    end
  endtask

  initial begin
    int ld0, fd0, le0;
    rst = 1'b1; pixel_clk = 1'b0; h_sync = 1'b1; v_sync = 1'b0;
`ifdef SPRITE_WINDOW_EN
    win_x = 5'd3; win_y = 4'd1; win_w = 5'd4; win_h = 4'd2;
`endif
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_h", int'(h_pos_out), 0);
    chk("rst_v", int'(v_pos_out), 0);
    chk("rst_active", int'(active_finder_position), 0);
    repeat (3) @(negedge clk);
    chk("held_hsync_no_edge", int'(active_finder_position), 0);
    h_sync = 1'b0;
    @(negedge clk);

    // Full line counted pixel by pixel.
    pulse_hs();
    chk("line_start_active", int'(active_finder_position), 1);
    chk("line_start_h", int'(h_pos_out), 0);
    pixels(H - 1);
    chk("h_at_last", int'(h_pos_out), H - 1);
    ld0 = ld_cnt;
    pixels(1);
    chk("line_done_count", ld_cnt - ld0, 1);
    chk("line_end_h", int'(h_pos_out), 0);
    chk("line_end_active", int'(active_finder_position), 0);
    chk("line_end_v", int'(v_pos_out), 1);

    // Finish the frame: one frame_done, rows wrap.
    fd0 = fd_cnt; ld0 = ld_cnt;
    full_lines(V - 1);
    chk("frame_done_count", fd_cnt - fd0, 1);
    chk("frame_lines", ld_cnt - ld0, V - 1);
    chk("frame_wrap_v", int'(v_pos_out), 0);

    // Short line aborted by an early h_sync.
    pulse_hs();
    pixels(5);
    ld0 = ld_cnt; le0 = le_cnt;
    pulse_hs();
    chk("short_err", le_cnt - le0, 1);
    chk("short_no_done", ld_cnt - ld0, 0);
    chk("short_h", int'(h_pos_out), 0);
    chk("short_active", int'(active_finder_position), 1);
    chk("short_v", int'(v_pos_out), 1);
    pixels(H);
    chk("after_short_v", int'(v_pos_out), 2);

    // Mid-line v_sync clears the row but not the column.
    pulse_hs();
    pixels(4);
    fd0 = fd_cnt;
    v_sync = 1'b1;
    @(negedge clk);
    v_sync = 1'b0;
    chk("vs_v", int'(v_pos_out), 0);
    chk("vs_h_held", int'(h_pos_out), 4);
    pixels(2);
    chk("vs_h_continues", int'(h_pos_out), 6);
    pixels(H - 6);
    chk("vs_no_frame_done", fd_cnt - fd0, 0);
    chk("vs_next_v", int'(v_pos_out), 1);

    // h_sync landing on the last pixel is a clean line end.
    pulse_hs();
    pixels(H - 1);
    ld0 = ld_cnt; le0 = le_cnt;
    pixel_clk = 1'b1; h_sync = 1'b1;
    @(negedge clk);
    pixel_clk = 1'b0; h_sync = 1'b0;
    chk("coinc_done", ld_cnt - ld0, 1);
    chk("coinc_no_err", le_cnt - le0, 0);
    chk("coinc_active", int'(active_finder_position), 1);
    chk("coinc_h", int'(h_pos_out), 0);
    chk("coinc_v", int'(v_pos_out), 2);
    pixels(H);

    // v_sync on the final pixel of the last row: clear wins, no frame_done.
    full_lines(V - 1 - 3);
    chk("last_row_v", int'(v_pos_out), V - 1);
    pulse_hs();
    pixels(H - 1);
    ld0 = ld_cnt; fd0 = fd_cnt;
    pixel_clk = 1'b1; v_sync = 1'b1;
    @(negedge clk);
    pixel_clk = 1'b0; v_sync = 1'b0;
    chk("vs_last_done", ld_cnt - ld0, 1);
    chk("vs_last_no_frame", fd_cnt - fd0, 0);
    chk("vs_last_v", int'(v_pos_out), 0);

    // Randomized traffic, including occasional mid-line resets.
    for (int i = 0; i < 20000; i++) begin
      pixel_clk = 1'($urandom_range(0, 1));
      h_sync    = ($urandom_range(0, 39) == 0);
      v_sync    = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 2999) == 0);
`ifdef SPRITE_WINDOW_EN
      if ($urandom_range(0, 99) == 0) begin
        win_x = HW'($urandom_range(0, H - 1));
        win_w = HW'($urandom_range(0, (1 << HW) - 1));
        win_y = VW'($urandom_range(0, V - 1));
        win_h = VW'($urandom_range(0, (1 << VW) - 1));
      end
`endif
      @(negedge clk);
    end
    rst = 1'b0; pixel_clk = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
